// File: rtl/prog_loader_if.sv
// Byte-stream and write-port bundle between the host, the loader and the accelerator core.
// The loader connects through the slave modport; the host/core side uses master.
interface prog_loader_if #(
    parameter int INSTR_W      = 32,
    parameter int INSTR_ADDR_W = 4,
    parameter int MEM_ADDR_W   = 5,
    parameter int DATA_W       = 8
);
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    instr_we;
    logic [INSTR_ADDR_W-1:0] instr_addr;
    logic [INSTR_W-1:0]      instr_wdata;
    logic                    mem_we;
    logic [MEM_ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    acc_start;
    logic                    acc_halted;
    logic                    busy;
    logic                    err;

    modport master (
        output in_data, in_valid, acc_halted,
        input  in_ready, instr_we, instr_addr, instr_wdata, mem_we, mem_addr,
               mem_wdata, acc_start, busy, err
    );

    modport slave (
        input  in_data, in_valid, acc_halted,
        output in_ready, instr_we, instr_addr, instr_wdata, mem_we, mem_addr,
               mem_wdata, acc_start, busy, err
    );
endinterface

// File: rtl/prog_loader.sv
// Packet decoder that loads instruction store / data memory from a byte stream and launches the core.
// Optional trailing checksum byte on load packets: define LOADER_CHECKSUM_EN.
//
// state     | meaning
// S_IDLE    | waiting for a command byte
// S_ADDR    | expecting the start address byte
// S_COUNT   | expecting the word/byte count
// S_PAYLOAD | receiving payload bytes, issuing writes
// S_CSUM    | expecting the checksum byte (LOADER_CHECKSUM_EN only)
// S_RUN     | core running, input blocked until acc_halted
module prog_loader #(
    parameter int INSTR_W      = 32,
    parameter int INSTR_ADDR_W = 4,
    parameter int MEM_ADDR_W   = 5,
    parameter int DATA_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    prog_loader_if.slave bus
);
    localparam int BYTES  = INSTR_W / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER = S_CSUM;
`else
    localparam state_t S_AFTER = S_IDLE;
`endif

    state_t              state, state_nxt;
    logic                err_r;
    logic                is_instr;
    logic [7:0]          ptr;
    logic [7:0]          cnt;
    logic [BIDX_W-1:0]   bidx;
    logic [INSTR_W-1:0]  word_sr;
    logic [INSTR_W-1:0]  word_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    logic accept, word_done, pay_last;
    logic wr_mem, wr_instr, do_start, set_err, clr_err;

    assign accept    = bus.in_valid && bus.in_ready;
    assign word_done = is_instr ? (bidx == BIDX_W'(BYTES - 1)) : 1'b1;
    assign pay_last  = word_done && (cnt == 8'd1);
    assign word_nxt  = (word_sr << 8) | INSTR_W'(bus.in_data);
    assign bus.err   = err_r;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (bus.in_data == 8'h01 || bus.in_data == 8'h02) state_nxt = S_ADDR;
                else if (bus.in_data == 8'h03 && !err_r)           state_nxt = S_RUN;
            end
            S_ADDR:    if (accept) state_nxt = S_COUNT;
            S_COUNT:   if (accept) state_nxt = (bus.in_data == 8'd0) ? S_AFTER : S_PAYLOAD;
            S_PAYLOAD: if (accept && pay_last) state_nxt = S_AFTER;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:    if (accept) state_nxt = S_IDLE;
`endif
            S_RUN:     if (bus.acc_halted) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_mem   = accept && (state == S_PAYLOAD) && !is_instr;
        wr_instr = accept && (state == S_PAYLOAD) && is_instr && word_done;
        do_start = accept && (state == S_IDLE) && (bus.in_data == 8'h03) && !err_r;
        clr_err  = accept && (state == S_IDLE) && (bus.in_data == 8'h04);
        set_err  = accept && (state == S_IDLE) &&
                   !(bus.in_data inside {8'h01, 8'h02, 8'h03, 8'h04});
`ifdef LOADER_CHECKSUM_EN
        if (accept && (state == S_CSUM) && (bus.in_data != csum)) set_err = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready    <= 1'b1;
            bus.busy        <= 1'b0;
            bus.instr_we    <= 1'b0;
            bus.instr_addr  <= '0;
            bus.instr_wdata <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.acc_start   <= 1'b0;
            err_r           <= 1'b0;
            is_instr        <= 1'b0;
            ptr             <= '0;
            cnt             <= '0;
            bidx            <= '0;
            word_sr         <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            bus.in_ready  <= (state_nxt != S_RUN);
            bus.busy      <= (state_nxt != S_IDLE);
            bus.instr_we  <= wr_instr;
            bus.mem_we    <= wr_mem;
            bus.acc_start <= do_start;
            if (set_err)      err_r <= 1'b1;
            else if (clr_err) err_r <= 1'b0;

            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                csum <= (state == S_IDLE) ? bus.in_data : (csum ^ bus.in_data);
`endif
                case (state)
                    S_IDLE:  is_instr <= (bus.in_data == 8'h01);
                    S_ADDR:  ptr <= bus.in_data;
                    S_COUNT: begin
                        cnt  <= bus.in_data;
                        bidx <= '0;
                    end
                    S_PAYLOAD: begin
                        if (is_instr) begin
                            word_sr <= word_nxt;
                            bidx    <= word_done ? '0 : bidx + 1'b1;
                            if (word_done) begin
                                cnt             <= cnt - 8'd1;
                                ptr             <= ptr + 8'd1;
                                bus.instr_addr  <= ptr[INSTR_ADDR_W-1:0];
                                bus.instr_wdata <= word_nxt;
                            end
                        end else begin
                            cnt           <= cnt - 8'd1;
                            ptr           <= ptr + 8'd1;
                            bus.mem_addr  <= ptr[MEM_ADDR_W-1:0];
                            bus.mem_wdata <= DATA_W'(bus.in_data);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: packets are built from the protocol rules and
// the expected memory/instruction writes are queued in a scoreboard.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.INSTR_W(32), .INSTR_ADDR_W(4), .MEM_ADDR_W(5), .DATA_W(8)) bus ();
    prog_loader dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_mem[$];
    wr_t  exp_instr[$];
    wr_t  wm, wi;
    bit   err_m = 1'b0;
    int   starts_exp = 0;
    int   starts_seen = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic acc_q;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // a byte accepted at a posedge must be followed by its strobe in the very next cycle
    always @(posedge clk) acc_q <= !rst && bus.in_valid && bus.in_ready;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) begin
                check("mem_we_latency", acc_q, 1'b1);
                check("mem_we_expected", exp_mem.size() != 0, 1'b1);
                if (exp_mem.size() != 0) begin
                    wm = exp_mem.pop_front();
                    check("mem_addr", bus.mem_addr, wm.addr);
                    check("mem_wdata", bus.mem_wdata, wm.data[7:0]);
                end
            end
            if (bus.instr_we) begin
                check("instr_we_latency", acc_q, 1'b1);
                check("instr_we_expected", exp_instr.size() != 0, 1'b1);
                if (exp_instr.size() != 0) begin
                    wi = exp_instr.pop_front();
                    check("instr_addr", bus.instr_addr, wi.addr);
                    check("instr_wdata", bus.instr_wdata, wi.data);
                end
            end
            if (bus.acc_start) begin
                starts_seen++;
                check("start_ready_low", bus.in_ready, 1'b0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            t++;
            if (t == 200) begin
                check("in_ready_timeout", bus.in_ready, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] pl[$], input int gap_max, input bit bad_csum);
        logic [7:0]  cs;
        logic [7:0]  n;
        logic [31:0] w;
        wr_t         e;
        n  = (cmd == 8'h01) ? 8'(pl.size() / 4) : 8'(pl.size());
        cs = cmd ^ addr ^ n;
        for (int i = 0; i < pl.size(); i++) cs = cs ^ pl[i];
        if (cmd == 8'h01) begin
            for (int i = 0; i < int'(n); i++) begin
                w = {pl[4*i], pl[4*i+1], pl[4*i+2], pl[4*i+3]};
                e.addr = (int'(addr) + i) % 16;
                e.data = w;
                exp_instr.push_back(e);
            end
        end else begin
            for (int i = 0; i < pl.size(); i++) begin
                e.addr = (int'(addr) + i) % 32;
                e.data = {24'd0, pl[i]};
                exp_mem.push_back(e);
            end
        end
        send_byte(cmd, $urandom_range(0, gap_max));
        send_byte(addr, $urandom_range(0, gap_max));
        send_byte(n, $urandom_range(0, gap_max));
        for (int i = 0; i < pl.size(); i++) send_byte(pl[i], $urandom_range(0, gap_max));
`ifdef LOADER_CHECKSUM_EN
        if (bad_csum) begin
            cs = cs ^ 8'($urandom_range(1, 255));
            err_m = 1'b1;
        end
        send_byte(cs, $urandom_range(0, gap_max));
`endif
        check("err_after_load", bus.err, err_m);
        check("idle_after_load", bus.busy, 1'b0);
    endtask

    task automatic start_run(input int run_cycles);
        send_byte(8'h03, 0);
        if (err_m) begin
            check("start_refused", bus.acc_start, 1'b0);
            check("busy_refused", bus.busy, 1'b0);
            check("ready_refused", bus.in_ready, 1'b1);
        end else begin
            starts_exp++;
            check("acc_start", bus.acc_start, 1'b1);
            check("busy_run", bus.busy, 1'b1);
            check("ready_run", bus.in_ready, 1'b0);
            repeat (run_cycles) begin
                @(posedge clk);
                #1;
                check("start_one_cycle", bus.acc_start, 1'b0);
                check("ready_in_run", bus.in_ready, 1'b0);
            end
            bus.acc_halted = 1'b1;
            @(posedge clk);
            #1;
            bus.acc_halted = 1'b0;
            check("ready_after_halt", bus.in_ready, 1'b1);
            check("busy_after_halt", bus.busy, 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] v;
        int         r;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.acc_halted = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_instr_we", bus.instr_we, 1'b0);
        check("rst_acc_start", bus.acc_start, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 5'd0);
        check("rst_instr_wdata", bus.instr_wdata, 32'd0);
        rst = 1'b0;

        // halted outside RUN has no effect
        bus.acc_halted = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.acc_halted = 1'b0;
        check("halt_ignored_busy", bus.busy, 1'b0);
        check("halt_ignored_ready", bus.in_ready, 1'b1);

        pl = {8'hAA, 8'hBB, 8'hCC};
        send_load(8'h02, 8'h08, pl, 0, 1'b0);
        pl = {8'h00, 8'h04, 8'h22, 8'h18, 8'h00, 8'h00, 8'h00, 8'h0A};
        send_load(8'h01, 8'h0F, pl, 0, 1'b0);
        start_run(3);

        send_byte(8'h7F, 0);
        err_m = 1'b1;
        check("bad_cmd_err", bus.err, 1'b1);
        start_run(2);
        send_byte(8'h04, 0);
        err_m = 1'b0;
        check("clear_err", bus.err, 1'b0);
        start_run(2);

        pl = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send_load(8'h01, 8'h03, pl, 4, 1'b0);

        // reset after two payload bytes of an instruction word: nothing may be written
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        err_m = 1'b0;
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_ready", bus.in_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid_no_instr", exp_instr.size(), 0);
        pl = {8'h11};
        send_load(8'h02, 8'h25, pl, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        pl = {8'h55};
        send_load(8'h02, 8'h00, pl, 0, 1'b0);
        send_load(8'h02, 8'h00, pl, 0, 1'b1);
        start_run(2);
        send_byte(8'h04, 0);
        err_m = 1'b0;
        check("csum_clear", bus.err, 1'b0);
`endif

        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 9);
            pl = {};
            if (r <= 3) begin
                repeat ($urandom_range(0, 6)) pl.push_back(8'($urandom));
                send_load(8'h02, 8'($urandom), pl, $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
            end else if (r <= 6) begin
                repeat (4 * $urandom_range(0, 3)) pl.push_back(8'($urandom));
                send_load(8'h01, 8'($urandom), pl, $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
            end else if (r == 7) begin
                start_run($urandom_range(1, 5));
            end else if (r == 8) begin
                do v = 8'($urandom); while (v >= 8'h01 && v <= 8'h04);
                send_byte(v, $urandom_range(0, 2));
                err_m = 1'b1;
                check("rand_bad_cmd_err", bus.err, 1'b1);
            end else begin
                send_byte(8'h04, $urandom_range(0, 2));
                err_m = 1'b0;
                check("rand_clear_err", bus.err, 1'b0);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("mem_queue_drained", exp_mem.size(), 0);
        check("instr_queue_drained", exp_instr.size(), 0);
        check("start_count", starts_seen, starts_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
